// File: rtl/pc_seq_pkg.sv
// Shared constants and types for the multi-cycle PC sequencer.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package pc_seq_pkg;

    // FSM state encodings
    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;

    // next-PC select codes
    localparam logic [1:0] NPC_SEQ    = 2'd0;  // PC+4
    localparam logic [1:0] NPC_BRANCH = 2'd1;  // PC+4+offset
    localparam logic [1:0] NPC_JUMP   = 2'd2;  // imm26 target
    localparam logic [1:0] NPC_JR     = 2'd3;  // register target

    // opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    // latched instruction fields the sequencer cares about
    typedef struct packed {
        logic [5:0] opcode;
        logic [5:0] funct;
    } instr_t;

    // instruction class, exactly one bit set
    typedef struct packed {
        logic j;
        logic jal;
        logic jr;
        logic beq;
        logic lw;
        logic sw;
        logic alu;
        logic nop;
    } instr_class_t;

endpackage

// File: rtl/pc_seq_ctrl_if.sv
// Bundle of instruction/ready inputs and datapath strobes around the sequencer.
// Latency: none (wires only).
// Backpressure: memories stall the sequencer by holding imem_ready/dmem_ready low.
interface pc_seq_ctrl_if;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       imem_ready;
    logic       dmem_ready;

    logic       imem_re;
    logic       ir_we;
    logic       pc_we;
    logic       reg_we;
    logic       dmem_re;
    logic       dmem_we;
    logic [1:0] npc_sel;
    logic [2:0] state;
    logic       fault;

    // sequencer side: consumes instruction bits and handshakes, drives strobes
    modport master (
        input  opcode, funct, zero, imem_ready, dmem_ready,
        output imem_re, ir_we, pc_we, reg_we, dmem_re, dmem_we, npc_sel, state, fault
    );

    // datapath/memory side: supplies instruction bits and handshakes, obeys strobes
    modport slave (
        output opcode, funct, zero, imem_ready, dmem_ready,
        input  imem_re, ir_we, pc_we, reg_we, dmem_re, dmem_we, npc_sel, state, fault
    );

endinterface

// File: rtl/pc_seq_decode.sv
// Classifies the latched opcode/funct into a one-hot instruction class.
// Latency: combinational.
// Backpressure: none.
module pc_seq_decode
    import pc_seq_pkg::*;
(
    input  instr_t       instr_i,
    output instr_class_t class_o
);

    // anything not recognised falls into the nop class
    always_comb begin
        class_o = '0;
        case (instr_i.opcode)
            OP_RTYPE: begin
                case (instr_i.funct)
                    FN_JR:            class_o.jr  = 1'b1;
                    FN_ADDU, FN_SUBU: class_o.alu = 1'b1;
                    default:          class_o.nop = 1'b1;
                endcase
            end
            OP_J:           class_o.j   = 1'b1;
            OP_JAL:         class_o.jal = 1'b1;
            OP_BEQ:         class_o.beq = 1'b1;
            OP_LW:          class_o.lw  = 1'b1;
            OP_SW:          class_o.sw  = 1'b1;
            OP_ORI, OP_LUI: class_o.alu = 1'b1;
            default:        class_o.nop = 1'b1;
        endcase
    end

endmodule

// File: rtl/pc_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer driving PC, IR, regfile and memory strobes.
// Latency: jumps 2, beq 3, ALU 4, sw 4, lw 5 cycles, plus memory wait cycles.
// Backpressure: waits in FETCH on imem_ready (faults after IMEM_TIMEOUT cycles), in MEM on dmem_ready.
// Optional retire counter output enabled by macro PC_SEQ_RETIRE_CNT_EN.
module pc_seq_ctrl
    import pc_seq_pkg::*;
#(
    parameter int IMEM_TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset_n,
    pc_seq_ctrl_if.master bus
`ifdef PC_SEQ_RETIRE_CNT_EN
    ,
    output logic [31:0]   retire_cnt
`endif
);

    // last wait-counter value before a missing fetch response becomes a fault
    localparam logic [3:0] WAIT_LAST = 4'(IMEM_TIMEOUT - 1);

    logic [2:0]   state_q, state_d;
    instr_t       ir_q;
    logic [3:0]   wait_cnt_q, wait_cnt_d;
    logic         fault_q, fault_d;
    instr_class_t cls;

    logic         imem_re_c, ir_we_c, pc_we_c, reg_we_c, dmem_re_c, dmem_we_c;
    logic [1:0]   npc_sel_c;

    pc_seq_decode u_decode (
        .instr_i (ir_q),
        .class_o (cls)
    );

    // next state and strobes from state, latched instruction and live ready/zero
    always_comb begin
        state_d    = ST_FETCH;
        wait_cnt_d = wait_cnt_q;
        fault_d    = fault_q;
        imem_re_c  = 1'b0;
        ir_we_c    = 1'b0;
        pc_we_c    = 1'b0;
        reg_we_c   = 1'b0;
        dmem_re_c  = 1'b0;
        dmem_we_c  = 1'b0;
        npc_sel_c  = NPC_SEQ;
        case (state_q)
            ST_FETCH: begin
                // a faulted sequencer parks here with the fetch port idle
                if (!fault_q) begin
                    imem_re_c = 1'b1;
                    if (bus.imem_ready) begin
                        ir_we_c    = 1'b1;
                        pc_we_c    = 1'b1;
                        npc_sel_c  = NPC_SEQ;
                        wait_cnt_d = '0;
                        state_d    = ST_DECODE;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        fault_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 4'd1;
                    end
                end
            end
            ST_DECODE: begin
                if (cls.j || cls.jal) begin
                    pc_we_c   = 1'b1;
                    npc_sel_c = NPC_JUMP;
                    reg_we_c  = cls.jal;
                end else if (cls.jr) begin
                    pc_we_c   = 1'b1;
                    npc_sel_c = NPC_JR;
                end else if (!cls.nop) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cls.beq) begin
                    // npc_sel only leaves PC+4 when the branch is actually taken
                    if (bus.zero) begin
                        pc_we_c   = 1'b1;
                        npc_sel_c = NPC_BRANCH;
                    end
                end else if (cls.lw || cls.sw) begin
                    state_d = ST_MEM;
                end else if (cls.alu) begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                dmem_re_c = cls.lw;
                dmem_we_c = cls.sw;
                if (!(cls.lw || cls.sw)) begin
                    state_d = ST_FETCH;
                end else if (!bus.dmem_ready) begin
                    state_d = ST_MEM;
                end else if (cls.lw) begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                reg_we_c = 1'b1;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // state, fetch wait counter and sticky fault
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_FETCH;
            wait_cnt_q <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            fault_q    <= fault_d;
        end
    end

    // instruction register captures opcode/funct on the fetch handshake
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_q <= '0;
        end else if (ir_we_c) begin
            ir_q <= '{opcode: bus.opcode, funct: bus.funct};
        end
    end

    // reset gates every strobe so the datapath sees silence even though FETCH is forced
    assign bus.imem_re = reset_n & imem_re_c;
    assign bus.ir_we   = reset_n & ir_we_c;
    assign bus.pc_we   = reset_n & pc_we_c;
    assign bus.reg_we  = reset_n & reg_we_c;
    assign bus.dmem_re = reset_n & dmem_re_c;
    assign bus.dmem_we = reset_n & dmem_we_c;
    assign bus.npc_sel = reset_n ? npc_sel_c : NPC_SEQ;
    assign bus.state   = state_q;
    assign bus.fault   = fault_q;

`ifdef PC_SEQ_RETIRE_CNT_EN
    logic [31:0] retire_q;

    // one count per instruction that returns to FETCH; wraps naturally
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retire_q <= '0;
        end else if ((state_q != ST_FETCH) && (state_d == ST_FETCH)) begin
            retire_q <= retire_q + 32'd1;
        end
    end

    assign retire_cnt = retire_q;
`endif

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Scoreboard bench for pc_seq_ctrl: per-cycle stimulus/expectation pairs are queued per instruction.
// Latency: n/a.
// Backpressure: imem_ready/dmem_ready scheduled by the stimulus entries.
module tb_pc_seq_ctrl;

    localparam logic [5:0] C_RTYPE = 6'h00;
    localparam logic [5:0] C_J     = 6'h02;
    localparam logic [5:0] C_JAL   = 6'h03;
    localparam logic [5:0] C_BEQ   = 6'h04;
    localparam logic [5:0] C_ORI   = 6'h0d;
    localparam logic [5:0] C_LUI   = 6'h0f;
    localparam logic [5:0] C_LW    = 6'h23;
    localparam logic [5:0] C_SW    = 6'h2b;
    localparam logic [5:0] C_FJR   = 6'h08;
    localparam logic [5:0] C_FADDU = 6'h21;
    localparam logic [5:0] C_FSUBU = 6'h23;

    // strobe vector order: imem_re ir_we pc_we reg_we dmem_re dmem_we
    localparam logic [5:0] S_NONE  = 6'b000000;
    localparam logic [5:0] S_IDLE  = 6'b100000;
    localparam logic [5:0] S_FETCH = 6'b111000;
    localparam logic [5:0] S_PC    = 6'b001000;
    localparam logic [5:0] S_PCREG = 6'b001100;
    localparam logic [5:0] S_REG   = 6'b000100;
    localparam logic [5:0] S_DRE   = 6'b000010;
    localparam logic [5:0] S_DWE   = 6'b000001;

    typedef struct packed {
        logic       imem_ready;
        logic       dmem_ready;
        logic       zero;
        logic [5:0] opcode;
        logic [5:0] funct;
    } stim_t;

    typedef struct packed {
        logic [2:0] state;
        logic [5:0] strobes;
        logic [1:0] npc_sel;
        logic       fault;
    } obs_t;

    typedef struct {
        stim_t s;
        obs_t  o;
    } entry_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    entry_t sb[$];
    int checks = 0;
    int errors = 0;
    int retired = 0;

    always #5 clk = ~clk;

    pc_seq_ctrl_if bus ();

`ifdef PC_SEQ_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    pc_seq_ctrl #(.IMEM_TIMEOUT(15)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef PC_SEQ_RETIRE_CNT_EN
        ,
        .retire_cnt (retire_cnt)
`endif
    );

    function automatic obs_t mk(input logic [2:0] st, input logic [5:0] strb, input logic [1:0] npc);
        obs_t r;
        r.state   = st;
        r.strobes = strb;
        r.npc_sel = npc;
        r.fault   = 1'b0;
        return r;
    endfunction

    function automatic obs_t sample();
        obs_t r;
        r.state   = bus.state;
        r.strobes = {bus.imem_re, bus.ir_we, bus.pc_we, bus.reg_we, bus.dmem_re, bus.dmem_we};
        r.npc_sel = bus.npc_sel;
        r.fault   = bus.fault;
        return r;
    endfunction

    task automatic drive(input stim_t s);
        bus.imem_ready = s.imem_ready;
        bus.dmem_ready = s.dmem_ready;
        bus.zero       = s.zero;
        bus.opcode     = s.opcode;
        bus.funct      = s.funct;
    endtask

    task automatic push(input stim_t s, input obs_t o);
        entry_t e;
        e.s = s;
        e.o = o;
        sb.push_back(e);
    endtask

    task automatic push_idle();
        stim_t s;
        s = '{imem_ready: 1'b0, dmem_ready: 1'b0, zero: 1'b0, opcode: C_J, funct: C_FJR};
        push(s, mk(3'd0, S_IDLE, 2'd0));
    endtask

    // reference model: the per-cycle trace one instruction should produce
    task automatic push_instr(input logic [5:0] op, input logic [5:0] fn, input logic z, input int mw);
        stim_t s;
        logic is_jr, is_alu, is_mem, is_beq;
        is_jr  = (op == C_RTYPE) && (fn == C_FJR);
        is_alu = ((op == C_RTYPE) && (fn == C_FADDU || fn == C_FSUBU)) || op == C_ORI || op == C_LUI;
        is_mem = (op == C_LW) || (op == C_SW);
        is_beq = (op == C_BEQ);
        retired++;
        s = '{imem_ready: 1'b1, dmem_ready: 1'b0, zero: ~z, opcode: op, funct: fn};
        push(s, mk(3'd0, S_FETCH, 2'd0));
        // after FETCH the live opcode bus carries a different instruction
        s.imem_ready = 1'b0;
        s.opcode     = (op == C_J) ? C_LW : C_J;
        s.funct      = C_FJR;
        if (op == C_J) begin
            push(s, mk(3'd1, S_PC, 2'd2));
            return;
        end
        if (op == C_JAL) begin
            push(s, mk(3'd1, S_PCREG, 2'd2));
            return;
        end
        if (is_jr) begin
            push(s, mk(3'd1, S_PC, 2'd3));
            return;
        end
        push(s, mk(3'd1, S_NONE, 2'd0));
        if (!(is_alu || is_mem || is_beq)) return;
        if (is_beq) begin
            s.zero = z;
            push(s, mk(3'd2, z ? S_PC : S_NONE, z ? 2'd1 : 2'd0));
            return;
        end
        push(s, mk(3'd2, S_NONE, 2'd0));
        if (is_mem) begin
            for (int i = 0; i < mw; i++) push(s, mk(3'd3, (op == C_LW) ? S_DRE : S_DWE, 2'd0));
            s.dmem_ready = 1'b1;
            push(s, mk(3'd3, (op == C_LW) ? S_DRE : S_DWE, 2'd0));
            s.dmem_ready = 1'b0;
            if (op == C_SW) return;
        end
        push(s, mk(3'd4, S_REG, 2'd0));
    endtask

    task automatic pop_drive(output entry_t e);
        e = sb.pop_front();
        @(posedge clk);
        #1;
        drive(e.s);
        @(negedge clk);
    endtask

    task automatic do_reset();
        stim_t s;
        s = '{imem_ready: 1'b0, dmem_ready: 1'b0, zero: 1'b0, opcode: 6'h00, funct: 6'h00};
        reset_n = 1'b0;
        drive(s);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        retired = 0;
    endtask

    task automatic test_reset();
        obs_t got;
        stim_t s;
        s = '{imem_ready: 1'b1, dmem_ready: 1'b1, zero: 1'b1, opcode: C_RTYPE, funct: C_FADDU};
        reset_n = 1'b0;
        drive(s);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            got = sample();
            checks++;
            if (got !== mk(3'd0, S_NONE, 2'd0)) begin
                errors++;
                $display("FAIL reset_hold[%0d] got=%b exp=%b", i, got, mk(3'd0, S_NONE, 2'd0));
            end
        end
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        reset_n = 1'b1;
        retired = 0;
        #1;
        got = sample();
        checks++;
        if (got !== mk(3'd0, S_IDLE, 2'd0)) begin
            errors++;
            $display("FAIL reset_release got=%b exp=%b", got, mk(3'd0, S_IDLE, 2'd0));
        end
`ifdef PC_SEQ_RETIRE_CNT_EN
        checks++;
        if (retire_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_retire got=%0d exp=0", retire_cnt);
        end
`endif
    endtask

    task automatic test_addu();
        entry_t e;
        obs_t got;
        int cyc = 0;
        push_instr(C_RTYPE, C_FADDU, 1'b0, 0);
        push_idle();
        while (sb.size() != 0) begin
            pop_drive(e);
            got = sample();
            checks++;
            if (got !== e.o) begin
                errors++;
                $display("FAIL addu cyc=%0d got=%b exp=%b", cyc, got, e.o);
            end
            cyc++;
        end
    endtask

    task automatic test_beq();
        entry_t e;
        obs_t got;
        int cyc = 0;
        push_instr(C_BEQ, 6'h15, 1'b1, 0);
        push_idle();
        push_instr(C_BEQ, 6'h2a, 1'b0, 0);
        push_idle();
        while (sb.size() != 0) begin
            pop_drive(e);
            got = sample();
            checks++;
            if (got !== e.o) begin
                errors++;
                $display("FAIL beq cyc=%0d got=%b exp=%b", cyc, got, e.o);
            end
            cyc++;
        end
    endtask

    task automatic test_lw_wait();
        entry_t e;
        obs_t got;
        int cyc = 0;
        push_instr(C_LW, 6'h04, 1'b0, 3);
        if (sb.size() != 8) begin
            errors++;
            $display("FAIL lw_len got=%0d exp=8", sb.size());
        end
        checks++;
        push_idle();
        while (sb.size() != 0) begin
            pop_drive(e);
            got = sample();
            checks++;
            if (got !== e.o) begin
                errors++;
                $display("FAIL lw_wait cyc=%0d got=%b exp=%b", cyc, got, e.o);
            end
            cyc++;
        end
    endtask

    task automatic test_jal();
        entry_t e;
        obs_t got;
        int cyc = 0;
        push_instr(C_JAL, 6'h3c, 1'b0, 0);
        push_idle();
        while (sb.size() != 0) begin
            pop_drive(e);
            got = sample();
            checks++;
            if (got !== e.o) begin
                errors++;
                $display("FAIL jal cyc=%0d got=%b exp=%b", cyc, got, e.o);
            end
            cyc++;
        end
    endtask

    task automatic test_back_to_back();
        entry_t e;
        obs_t got;
        int cyc = 0;
        push_instr(C_J, 6'h11, 1'b0, 0);
        push_instr(C_RTYPE, C_FJR, 1'b1, 0);
        push_instr(C_SW, 6'h00, 1'b0, 0);
        push_instr(C_ORI, 6'h21, 1'b1, 0);
        push_instr(C_LUI, 6'h00, 1'b0, 0);
        push_instr(C_RTYPE, C_FSUBU, 1'b0, 0);
        push_instr(6'h3f, 6'h08, 1'b0, 0);
        push_instr(C_RTYPE, 6'h00, 1'b1, 0);
        push_instr(C_SW, 6'h01, 1'b0, 2);
        push_instr(C_LW, 6'h02, 1'b1, 0);
        push_idle();
        while (sb.size() != 0) begin
            pop_drive(e);
            got = sample();
            checks++;
            if (got !== e.o) begin
                errors++;
                $display("FAIL b2b cyc=%0d got=%b exp=%b", cyc, got, e.o);
            end
            cyc++;
        end
`ifdef PC_SEQ_RETIRE_CNT_EN
        checks++;
        if (retire_cnt !== 32'(retired)) begin
            errors++;
            $display("FAIL retire_cnt got=%0d exp=%0d", retire_cnt, retired);
        end
`endif
    endtask

    task automatic test_timeout();
        obs_t got;
        obs_t exp;
        do_reset();
        #1;
        for (int k = 0; k < 15; k++) begin
            if (k != 0) @(negedge clk);
            got = sample();
            checks++;
            if (got !== mk(3'd0, S_IDLE, 2'd0)) begin
                errors++;
                $display("FAIL timeout_wait[%0d] got=%b exp=%b", k, got, mk(3'd0, S_IDLE, 2'd0));
            end
        end
        exp = mk(3'd0, S_NONE, 2'd0);
        exp.fault = 1'b1;
        @(negedge clk);
        bus.imem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k != 0) @(negedge clk);
            got = sample();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL timeout_fault[%0d] got=%b exp=%b", k, got, exp);
            end
            bus.imem_ready = 1'b1;
        end
        @(negedge clk);
        reset_n = 1'b0;
        #2;
        got = sample();
        checks++;
        if (got !== mk(3'd0, S_NONE, 2'd0)) begin
            errors++;
            $display("FAIL timeout_clear got=%b exp=%b", got, mk(3'd0, S_NONE, 2'd0));
        end
        bus.imem_ready = 1'b0;
        reset_n = 1'b1;
        retired = 0;
        @(negedge clk);
        got = sample();
        checks++;
        if (got !== mk(3'd0, S_IDLE, 2'd0)) begin
            errors++;
            $display("FAIL timeout_restart got=%b exp=%b", got, mk(3'd0, S_IDLE, 2'd0));
        end
    endtask

    task automatic test_reset_mid_sw();
        entry_t e;
        obs_t got;
        push_instr(C_SW, 6'h07, 1'b0, 5);
        for (int cyc = 0; cyc < 4; cyc++) begin
            pop_drive(e);
            got = sample();
            checks++;
            if (got !== e.o) begin
                errors++;
                $display("FAIL sw_pre cyc=%0d got=%b exp=%b", cyc, got, e.o);
            end
        end
        #2;
        reset_n = 1'b0;
        #1;
        got = sample();
        checks++;
        if (got !== mk(3'd0, S_NONE, 2'd0)) begin
            errors++;
            $display("FAIL sw_reset got=%b exp=%b", got, mk(3'd0, S_NONE, 2'd0));
        end
        sb.delete();
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        retired = 0;
        #1;
        got = sample();
        checks++;
        if (got !== mk(3'd0, S_IDLE, 2'd0)) begin
            errors++;
            $display("FAIL sw_release got=%b exp=%b", got, mk(3'd0, S_IDLE, 2'd0));
        end
`ifdef PC_SEQ_RETIRE_CNT_EN
        checks++;
        if (retire_cnt !== 32'd0) begin
            errors++;
            $display("FAIL sw_retire got=%0d exp=0", retire_cnt);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_addu();
        test_beq();
        test_lw_wait();
        test_jal();
        test_back_to_back();
        test_timeout();
        test_reset_mid_sw();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
